// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader:
// FSM state encoding, header length and word geometry.
package imem_loader_pkg;

    localparam int unsigned WordW        = 32;
    localparam int unsigned HdrBytes     = 2;
    localparam int unsigned BytesPerWord = WordW / 8;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StHdrHi = 3'd1,
        StHdrLo = 3'd2,
        StData  = 3'd3,
        StLast  = 3'd4,
        StCksum = 3'd5,
        StDone  = 3'd6,
        StErr   = 3'd7
    } state_t;

    // States in which the loader is willing to take a stream byte.
    function automatic logic state_accepts(state_t s);
        return (s == StHdrHi) || (s == StHdrLo) || (s == StData) || (s == StCksum);
    endfunction

endpackage

// File: rtl/imem_loader_byte_word_assembler.sv
// Big-endian byte-to-word assembler: counts bytes within a word, shifts them
// in MSB first and emits a registered one-cycle word_valid after the last byte.
module byte_word_assembler
    import imem_loader_pkg::*;
#(
    parameter int unsigned N = WordW
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         byte_en,
    input  logic [7:0]   byte_in,
    output logic         word_end,
    output logic         word_valid,
    output logic [N-1:0] word
);

    localparam int unsigned Bytes = N / 8;
    localparam int unsigned CntW  = (Bytes > 1) ? $clog2(Bytes) : 1;

    logic [CntW-1:0] byte_cnt_q;
    logic [N-1:0]    sr_q;
    logic            word_valid_q;

    // Combinational: this accepted byte completes the current word.
    assign word_end   = byte_en && (byte_cnt_q == CntW'(Bytes - 1));
    assign word_valid = word_valid_q;
    assign word       = sr_q;

    // Byte counter, shift register and delayed word-complete pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt_q   <= '0;
            sr_q         <= '0;
            word_valid_q <= 1'b0;
        end else begin
            word_valid_q <= word_end;
            if (clear) begin
                byte_cnt_q <= '0;
            end else if (byte_en) begin
                byte_cnt_q <= word_end ? '0 : byte_cnt_q + 1'b1;
            end
            // Shift only on acceptance so a pending word survives the write pulse.
            if (byte_en) begin
                sr_q <= {sr_q[N-9:0], byte_in};
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader. Receives a byte stream (2-byte word
// count, then big-endian words), writes the instruction memory and holds the
// CPU in reset until the image is complete.
// Optional feature: define IMEM_LOADER_CKSUM_EN to require a trailing XOR
// checksum byte before the load is declared done.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned N      = WordW,
    parameter int unsigned N_REG  = 256,
    localparam int unsigned ADDR_W = $clog2(N_REG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [N-1:0]      imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int unsigned CntW = HdrBytes * 8;

    state_t            state_q, state_d;
    logic [CntW-1:0]   cnt_q;
    logic [ADDR_W:0]   idx_q;
    logic              accept;
    logic              restart;
    logic              data_byte;
    logic              word_end;
    logic              last_word;
    logic [CntW-1:0]   hdr_cnt;

    assign in_ready  = state_accepts(state_q);
    assign accept    = in_valid && in_ready;
    assign restart   = start && ((state_q == StIdle) || (state_q == StDone) ||
                                 (state_q == StErr));
    assign data_byte = accept && (state_q == StData);
    assign hdr_cnt   = {cnt_q[CntW-1:8], in_data};
    // Word index only advances on the write pulse, so while the last word is
    // being received it still equals that word's index.
    assign last_word = (CntW'(idx_q) + CntW'(1)) == cnt_q;

    byte_word_assembler #(
        .N (N)
    ) u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (restart),
        .byte_en    (data_byte),
        .byte_in    (in_data),
        .word_end   (word_end),
        .word_valid (imem_we),
        .word       (imem_wdata)
    );

    assign imem_addr    = idx_q[ADDR_W-1:0];
    assign words_loaded = idx_q;
    assign done         = (state_q == StDone);
    assign error        = (state_q == StErr);
    assign cpu_hold     = (state_q != StDone);

`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0] xor_q;

    // Running XOR over payload bytes, restarted with each load.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            xor_q <= 8'h00;
        end else if (data_byte) begin
            xor_q <= xor_q ^ in_data;
        end
    end
`endif

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) state_d = StHdrHi;
            end
            StHdrHi: begin
                if (accept) state_d = StHdrLo;
            end
            StHdrLo: begin
                if (accept) begin
                    if (hdr_cnt > CntW'(N_REG)) begin
                        state_d = StErr;
                    end else if (hdr_cnt == '0) begin
`ifdef IMEM_LOADER_CKSUM_EN
                        state_d = StCksum;
`else
                        state_d = StDone;
`endif
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (word_end && last_word) state_d = StLast;
            end
            StLast: begin
`ifdef IMEM_LOADER_CKSUM_EN
                state_d = StCksum;
`else
                state_d = StDone;
`endif
            end
`ifdef IMEM_LOADER_CKSUM_EN
            StCksum: begin
                if (accept) state_d = (in_data == xor_q) ? StDone : StErr;
            end
`endif
            StDone, StErr: begin
                if (start) state_d = StHdrHi;
            end
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Header word count, MSB byte first.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (accept && (state_q == StHdrHi)) begin
            cnt_q[CntW-1:8] <= in_data;
        end else if (accept && (state_q == StHdrLo)) begin
            cnt_q[7:0] <= in_data;
        end
    end

    // Word index / words_loaded: advances on each write pulse.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            idx_q <= '0;
        end else if (imem_we) begin
            idx_q <= idx_q + 1'b1;
        end
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory writer for the 5-stage MIPS pipeline: accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit words and drives the write port of the instruction memory that the fetch stage reads asynchronously. Holds the pipeline in reset (`cpu_hold`) until the image is fully written, then releases it so fetch starts at PC 0 with a complete program.

## Interface
- `N`, 32, instruction word width (bits)
- `N_REG`, 256, instruction memory depth (words); `ADDR_W = $clog2(N_REG)`
- `clk  input  1  clock, all state changes on posedge`
- `reset  input  1  synchronous, active-high reset`
- `start  input  1  begin a load; sampled in IDLE, DONE, ERR only`
- `in_data  input  8  stream byte`
- `in_valid  input  1  in_data valid`
- `in_ready  output  1  loader accepts a byte this cycle`
- `imem_we  output  1  instruction memory write enable, one-cycle pulse per word`
- `imem_addr  output  ADDR_W  word address of the write`
- `imem_wdata  output  N  word written`
- `cpu_hold  output  1  drives pipeline reset; high until load completes`
- `done  output  1  load completed successfully (level)`
- `error  output  1  load aborted (level)`
- `words_loaded  output  ADDR_W+1  words written in current load`

## Operation
- Byte accepted on a posedge where `in_valid && in_ready`; `in_ready` is a function of state only (high in HDR_HI, HDR_LO, DATA, CKSUM).
- Stream format: 2-byte word count `cnt` (MSB first), then `cnt*4` payload bytes, each word MSB first (first byte -> bits 31:24).
- States: IDLE -> (start) HDR_HI -> (byte) HDR_LO -> (byte) DATA | DONE | ERR; DATA -> (last byte) LAST -> DONE (or CKSUM, see Configuration); DONE/ERR -> (start) HDR_HI.
- After HDR_LO: `cnt > N_REG` -> ERR; `cnt == 0` -> DONE (no writes); else DATA.
- DATA: 2-bit byte counter, 32-bit shift register. On acceptance of byte 3 of a word, the next cycle presents `imem_we=1`, `imem_addr=word index`, `imem_wdata=assembled word`; word index and `words_loaded` increment on that same edge. Next word's bytes may be accepted during the write pulse.
- LAST: one cycle, `in_ready=0`, carries the final write pulse.
- DONE: `done=1`, `cpu_hold=0`, `in_ready=0`. ERR: `error=1`, `cpu_hold=1`, `in_ready=0`.
- `start` in DONE/ERR clears `done`, `error`, `words_loaded`, word index, re-asserts `cpu_hold` on the same edge; `start` in any other state ignored.
- Addresses beyond `cnt` never written; memory not cleared by reset or restart.

## Timing
- Reset values: state IDLE, `in_ready=0`, `imem_we=0`, `imem_addr=0`, `imem_wdata=0`, `cpu_hold=1`, `done=0`, `error=0`, `words_loaded=0`.
- Write latency: 1 cycle from 4th byte acceptance to `imem_we` high; pulse exactly 1 cycle.
- Full rate: one byte/cycle sustained; `N_REG` words take `4*N_REG+2` accepted bytes + 1 (LAST) cycle.
- `done` and `cpu_hold` deassert change on the edge after the final write pulse, never before the last write is visible.
- `reset` mid-load: all outputs to reset values next edge; partial image left in memory; `imem_we` never high in the cycle after reset.
- `in_valid` low stalls without state change; byte counter and shift register hold.

## Configuration
- `IMEM_LOADER_CKSUM_EN` defined: after the last payload byte (or after header when `cnt==0`) state goes to CKSUM, accepts one byte; equals XOR of all payload bytes (0 for `cnt==0`) -> DONE, else ERR. Writes already performed stay.
- Not defined: no CKSUM state, no running XOR register; LAST -> DONE directly.

## Structure
- Shared package: state encoding constants (IDLE, HDR_HI, HDR_LO, DATA, LAST, CKSUM, DONE, ERR), header byte count (2), bytes per word (N/8).
- One sub-module: `byte_word_assembler` (byte counter + shift register, `word_valid` pulse output); FSM, address counter and checksum live in the top.

## Test plan
- Reset then `start`, stream 00 02 | 12 34 56 78 | 9A BC DE F0 back-to-back -> writes 0x12345678 @0, 0x9ABCDEF0 @1, one-cycle pulses; `done=1`, `cpu_hold=0`, `words_loaded=2`.
- Header 00 00 -> DONE with no `imem_we`; header 01 01 (257 > 256) -> ERR, `cpu_hold=1`, `in_ready=0`.
- Random `in_valid` gaps on 3-word load -> identical memory contents and addresses as gapless run.
- `reset` asserted after 5 payload bytes -> next cycle IDLE, all outputs at reset values; new `start` + full stream loads correctly from address 0.
- `start` during DATA ignored; `start` in DONE -> `done` clears, `cpu_hold=1`, reload of 1 word overwrites address 0.
- With `IMEM_LOADER_CKSUM_EN`: 00 01 | 01 02 03 04 | 04 -> DONE; trailing 05 -> ERR, word still at address 0.
